// File: rtl/uart_frame_sender.sv
// Snapshots NCH channel values on a send request and feeds them byte by byte to a UART TX.
// Define UART_FRAME_CHECKSUM_EN to append an XOR checksum byte to every frame.
module uart_frame_sender #(
  parameter int unsigned NCH = 13,
  parameter int unsigned DW  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic              tx_done_tick,
  output logic              tx_start,
  output logic [7:0]        din,
  output logic              busy,
  output logic              frame_done_tick
);

  localparam int unsigned KW = $clog2(2 * NCH + 3);
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int unsigned LastInt = 2 * NCH + 2;
`else
  localparam int unsigned LastInt = 2 * NCH + 1;
`endif
  localparam logic [KW-1:0] LastIdx = KW'(LastInt);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [NCH*DW-1:0] snap_q, snap_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        din_q, din_d;
  logic              fdone_q, fdone_d;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic [KW-1:0] nxt_k;
  logic [7:0]    nxt_byte;
  int unsigned   off;
  logic [15:0]   slot;

  // Byte at index k+1; index 0 (header) is loaded directly on acceptance.
  always_comb begin
    nxt_k    = k_q + KW'(1);
    off      = 0;
    slot     = '0;
    nxt_byte = 8'h00;
    if (nxt_k == KW'(1)) begin
      nxt_byte = 8'(NCH);
    end else if (32'(nxt_k) <= 2 * NCH + 1) begin
      off      = 32'(nxt_k) - 2;
      slot     = 16'(snap_q[(off >> 1) * DW +: DW]);
      nxt_byte = off[0] ? slot[7:0] : slot[15:8];
    end
`ifdef UART_FRAME_CHECKSUM_EN
    else begin
      nxt_byte = chk_q;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    snap_d     = snap_q;
    tx_start_d = 1'b0;
    din_d      = din_q;
    fdone_d    = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    case (state_q)
      StIdle: begin
        // The completion cycle still counts as busy, so a send there is dropped.
        if (send && !fdone_q) begin
          snap_d     = ch_data;
          k_d        = '0;
          din_d      = 8'hA5;
          tx_start_d = 1'b1;
          state_d    = StStart;
`ifdef UART_FRAME_CHECKSUM_EN
          chk_d      = 8'hA5;
`endif
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (tx_done_tick) begin
          if (k_q == LastIdx) begin
            fdone_d = 1'b1;
            state_d = StIdle;
          end else begin
            k_d        = nxt_k;
            din_d      = nxt_byte;
            tx_start_d = 1'b1;
            state_d    = StStart;
`ifdef UART_FRAME_CHECKSUM_EN
            chk_d      = chk_q ^ nxt_byte;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      k_q        <= '0;
      snap_q     <= '0;
      tx_start_q <= 1'b0;
      din_q      <= 8'h00;
      fdone_q    <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      snap_q     <= snap_d;
      tx_start_q <= tx_start_d;
      din_q      <= din_d;
      fdone_q    <= fdone_d;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign tx_start        = tx_start_q;
  assign din             = din_q;
  assign busy            = (state_q != StIdle);
  assign frame_done_tick = fdone_q;

endmodule

// File: doc/uart_frame_sender.md
# uart_frame_sender

Upstream feeder for the UART transmitter. On a `send` strobe it snapshots all measured channel values, then serializes them into a fixed byte frame. Bytes go out one at a time over the transmitter's `tx_start`/`din`/`tx_done_tick` handshake. It sits between the channel measurement registers and the UART TX, so a full 13-channel voltage frame leaves the board per request.

## Interface
- `NCH`, 13: number of channels per frame (1..31).
- `DW`, 12: bits per channel value (9..16). Each value is zero-extended to a 16-bit slot.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `send` in 1: frame request, sampled each cycle; acted on only when idle.
- `ch_data` in NCH*DW: packed channel values; channel i = `ch_data[i*DW +: DW]`.
- `tx_done_tick` in 1: byte-complete pulse from the UART TX.
- `tx_start` out 1: one-cycle byte-start pulse to the UART TX (registered).
- `din` out 8: byte to transmit (registered); stable from `tx_start` until the matching `tx_done_tick`.
- `busy` out 1: high from frame acceptance until frame completion.
- `frame_done_tick` out 1: one-cycle pulse after the last byte completes.

## Operation
- Frame byte order, with index k running 0..LAST:
  - 0xA5 (header);
  - NCH[7:0];
  - for each ch 0..NCH-1: slot[15:8], then slot[7:0];
  - checksum byte (see Configuration).
- LAST = 2*NCH+2 with checksum, 2*NCH+1 without. NCH=13 gives 29 or 28 bytes.
- FSM states:
  - IDLE: `busy`=0. If `send`=1, latch `ch_data` into the snapshot register, k←0, chk←0, go to START.
  - START: `tx_start`=1 for exactly this cycle; `din`=byte(k); chk←chk^byte(k); go to WAIT.
  - WAIT: hold `din`. On `tx_done_tick`:
    - if k==LAST, go to IDLE and pulse `frame_done_tick`;
    - else k←k+1 and go to START.
- The snapshot isolates the frame from `ch_data` changes during transmission. Values are sampled only in the acceptance cycle.
- Ignored inputs:
  - `send` while `busy`=1 is ignored, including the cycle `frame_done_tick` fires. There is no queueing.
  - `tx_done_tick` in IDLE or START is ignored.
- Reset values: `tx_start`=0, `din`=0x00, `busy`=0, `frame_done_tick`=0, state IDLE, k=0, chk=0.
- Reset mid-frame: return to IDLE immediately; the frame is abandoned. A byte already started in the UART TX completes on the line; it is the receiver's job to resync on 0xA5.

## Timing
- `send` sampled high at edge T (state IDLE) → `busy`=1 and `tx_start`=1 with `din`=0xA5 during cycle T..T+1.
- `tx_done_tick` sampled high at edge E in WAIT:
  - for a non-last byte, `tx_start`=1 with the next `din` during the cycle after E;
  - for the last byte, `frame_done_tick`=1 and `busy`=0 during the cycle after E.
- This matches the UART TX returning to idle one cycle after its done tick. No extra gap is inserted.
- Frame duration = sum of byte times + 1 cycle per byte of handshake overhead.
- Index counter width is clog2(2*NCH+3). Checksum is an 8-bit XOR with no carry.

## Configuration
- `UART_FRAME_CHECKSUM_EN` defined: the frame ends with a checksum byte equal to the XOR of all preceding bytes, header and count included.
- Not defined: no checksum byte, LAST = 2*NCH+1, and the chk register is not built.

## Test plan
- NCH=13, DW=12, ch i = 0x100+i, checksum on, bench UART model returns `tx_done_tick` 20 cycles after each `tx_start`:
  - expected frame: A5 0D 01 00 01 01 … 01 0C, then checksum = XOR of the 28 bytes;
  - expect 29 `tx_start` pulses, a single `frame_done_tick`, and `busy` high throughout.
- Same stimulus with the macro undefined → exactly 28 bytes, with the last byte 0x0C.
- `send` re-pulsed mid-frame, and `ch_data` changed to all 0xFFF after acceptance → no second frame; bytes still reflect the snapshot (0x01xx).
- `rst_n` low during byte 10 → `tx_start`/`busy`/`din` go to 0 immediately; the next `send` restarts the frame at 0xA5.
- `send` held high continuously → frames back-to-back. The new frame's `tx_start` appears 2 cycles after `frame_done_tick` (1 idle cycle to accept).
- Spurious `tx_done_tick` while IDLE, and in the START cycle → no state change and no extra byte.
